// File: rtl/display_step_ctrl.sv
// Single-step controller: debounced step/select buttons, one-cycle cpu_en,
// and sequential double-dabble of pc/register low bytes for the display.

module display_step_ctrl_db #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(N + 1);

    logic          s1;
    logic          s2;
    logic          lvl;
    logic [CW-1:0] cnt;

    // Counter only advances while the synchronized level disagrees with lvl
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(N - 1)) begin
                cnt   <= '0;
                lvl   <= s2;
                press <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module display_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_step,
    input  logic        btn_sel,
    input  logic        halt,
    input  logic [31:0] pc,
    input  logic [31:0] rf_rdata,
    output logic        cpu_en,
    output logic [4:0]  rf_raddr,
    output logic [7:0]  pc_bcd,
    output logic [7:0]  reg_bcd,
    output logic [3:0]  final_code,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE,
        STEP,
        SETTLE,
        LOAD,
        CONV,
        SHOW
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        step_p;
    logic        sel_p;
    logic [7:0]  pc_bin;
    logic [7:0]  rf_bin;
    logic [11:0] pc_acc;
    logic [11:0] rf_acc;
    logic [11:0] pc_adj;
    logic [11:0] rf_adj;
    logic        pc_ovf;
    logic        rf_ovf;
    logic [3:0]  cnt;

    display_step_ctrl_db #(.N(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_step),
        .press (step_p)
    );

    display_step_ctrl_db #(.N(DEBOUNCE_CYCLES)) u_db_sel (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_sel),
        .press (sel_p)
    );

    function automatic logic [11:0] dab_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign pc_adj = dab_adj(pc_acc);
    assign rf_adj = dab_adj(rf_acc);
    assign cpu_en = (state == STEP);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_n;
    end

    // Step wins over select; a step while halted is simply discarded
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (step_p) begin
                    if (!halt) state_n = STEP;
                end else if (sel_p) begin
                    state_n = LOAD;
                end
            end
            STEP:    state_n = SETTLE;
            SETTLE:  state_n = LOAD;
            LOAD:    state_n = CONV;
            CONV:    if (cnt == 4'd1) state_n = SHOW;
            SHOW:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_raddr   <= '0;
            pc_bcd     <= 8'h00;
            reg_bcd    <= 8'h00;
            final_code <= 4'd0;
            pc_bin     <= '0;
            rf_bin     <= '0;
            pc_acc     <= '0;
            rf_acc     <= '0;
            pc_ovf     <= 1'b0;
            rf_ovf     <= 1'b0;
            cnt        <= '0;
        end else begin
            if (halt) final_code <= 4'd1;
            if (state == IDLE && !step_p && sel_p)
                rf_raddr <= rf_raddr + 5'd1;
            if (state == LOAD) begin
                pc_bin <= pc[7:0];
                rf_bin <= rf_rdata[7:0];
                pc_ovf <= (pc[31:8] != 24'd0);
                rf_ovf <= (rf_rdata[31:8] != 24'd0);
                pc_acc <= '0;
                rf_acc <= '0;
                cnt    <= 4'd8;
            end
            if (state == CONV) begin
                {pc_acc, pc_bin} <= {pc_adj[10:0], pc_bin, 1'b0};
                {rf_acc, rf_bin} <= {rf_adj[10:0], rf_bin, 1'b0};
                cnt              <= cnt - 4'd1;
            end
            if (state == SHOW) begin
                pc_bcd  <= (pc_acc[11:8] != 4'd0 || pc_ovf)
                           ? 8'hFF : pc_acc[7:0];
                reg_bcd <= (rf_acc[11:8] != 4'd0 || rf_ovf)
                           ? 8'hFF : rf_acc[7:0];
            end
        end
    end
endmodule

// File: tb/tb_display_step_ctrl.sv
// Directed bench for display_step_ctrl with a short debounce window.

module tb_display_step_ctrl;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_step = 1'b0;
    logic        btn_sel = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] rf_rdata;
    logic        cpu_en;
    logic [4:0]  rf_raddr;
    logic [7:0]  pc_bcd;
    logic [7:0]  reg_bcd;
    logic [3:0]  final_code;
    logic        busy;
    logic [31:0] regs [32];

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    logic prev_en = 1'b0;

    display_step_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_step   (btn_step),
        .btn_sel    (btn_sel),
        .halt       (halt),
        .pc         (pc),
        .rf_rdata   (rf_rdata),
        .cpu_en     (cpu_en),
        .rf_raddr   (rf_raddr),
        .pc_bcd     (pc_bcd),
        .reg_bcd    (reg_bcd),
        .final_code (final_code),
        .busy       (busy)
    );

    assign rf_rdata = regs[rf_raddr];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_en && !prev_en) pulses++;
        prev_en = cpu_en;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_bcd(input logic [31:0] v);
        logic [3:0] t;
        logic [3:0] u;
        if (v > 32'd99) return 8'hFF;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic wait_en(input string tag);
        int n;
        n = 0;
        while (!cpu_en && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_en_seen"}, 32'(cpu_en), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic step_seq(input string tag, input logic [7:0] epc,
                            input logic [7:0] erf);
        int p0;
        p0 = pulses;
        btn_step = 1'b1;
        wait_en(tag);
        @(negedge clk);
        chk({tag, "_en_width"}, 32'(cpu_en), 32'd0);
        repeat (10) @(negedge clk);
        chk({tag, "_show_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pc_bcd"}, 32'(pc_bcd), 32'(epc));
        chk({tag, "_reg_bcd"}, 32'(reg_bcd), 32'(erf));
        btn_step = 1'b0;
        repeat (12) @(negedge clk);
        chk({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
    endtask

    task automatic sel_seq(input string tag);
        int n;
        logic [4:0] old;
        logic [4:0] e;
        old = rf_raddr;
        e = old + 5'd1;
        btn_sel = 1'b1;
        n = 0;
        while (rf_raddr == old && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_raddr"}, 32'(rf_raddr), 32'(e));
        repeat (9) @(negedge clk);
        chk({tag, "_show_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_reg_bcd"}, 32'(reg_bcd), 32'(exp_bcd(regs[e])));
        btn_sel = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int p0;
        regs[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = 32'(i * 3);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_en", 32'(cpu_en), 32'd0);
        chk("rst_pc", 32'(pc_bcd), 32'h00);
        chk("rst_reg", 32'(reg_bcd), 32'h00);
        chk("rst_raddr", 32'(rf_raddr), 32'd0);
        chk("rst_final", 32'(final_code), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_busy", 32'(busy), 32'd1);
        wait_idle("rel");
        chk("rel_pc", 32'(pc_bcd), 32'h00);
        chk("rel_reg", 32'(reg_bcd), 32'h00);
        chk("rel_pulses", 32'(pulses), 32'd0);

        // bouncing step
        pc = 32'd36;
        regs[0] = 32'd7;
        repeat (3) begin
            btn_step = 1'b1;
            @(negedge clk);
            btn_step = 1'b0;
            @(negedge clk);
        end
        step_seq("step36", 8'h36, 8'h07);

        // select walk with wrap
        for (int i = 0; i < 33; i++) sel_seq($sformatf("sel%0d", i));
        chk("sel_final_raddr", 32'(rf_raddr), 32'd1);

        // range limits
        pc = 32'd100;
        regs[1] = 32'h0000_0105;
        step_seq("ovf100", 8'hFF, 8'hFF);
        pc = 32'd99;
        regs[1] = 32'd99;
        step_seq("max99", 8'h99, 8'h99);
        pc = 32'h0000_0100;
        regs[1] = 32'd64;
        step_seq("ovf256", 8'hFF, 8'h64);

        // halt: step discarded, final_code sticky
        halt = 1'b1;
        repeat (2) @(negedge clk);
        chk("halt_final", 32'(final_code), 32'd1);
        p0 = pulses;
        btn_step = 1'b1;
        repeat (15) @(negedge clk);
        chk("halt_busy", 32'(busy), 32'd0);
        btn_step = 1'b0;
        repeat (12) @(negedge clk);
        chk("halt_no_en", 32'(pulses - p0), 32'd0);
        halt = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt_sticky", 32'(final_code), 32'd1);

        // reset while cpu_en is high
        pc = 32'd42;
        regs[0] = 32'd17;
        btn_step = 1'b1;
        wait_en("rstep");
        reset = 1'b1;
        #1;
        chk("rstep_en", 32'(cpu_en), 32'd0);
        chk("rstep_busy", 32'(busy), 32'd1);
        chk("rstep_raddr", 32'(rf_raddr), 32'd0);
        chk("rstep_pc", 32'(pc_bcd), 32'h00);
        chk("rstep_final", 32'(final_code), 32'd0);
        btn_step = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wait_idle("rstep");
        chk("rstep_pc_refresh", 32'(pc_bcd), 32'h42);
        chk("rstep_reg_refresh", 32'(reg_bcd), 32'h17);

        // reset during CONV
        btn_step = 1'b1;
        wait_en("rconv");
        repeat (4) @(negedge clk);
        chk("rconv_in_conv", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rconv_pc", 32'(pc_bcd), 32'h00);
        chk("rconv_reg", 32'(reg_bcd), 32'h00);
        chk("rconv_en", 32'(cpu_en), 32'd0);
        btn_step = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wait_idle("rconv");
        chk("rconv_pc_refresh", 32'(pc_bcd), 32'h42);

        // simultaneous step + sel: step wins
        btn_sel = 1'b1;
        step_seq("both", 8'h42, 8'h17);
        btn_sel = 1'b0;
        repeat (12) @(negedge clk);
        chk("both_raddr", 32'(rf_raddr), 32'd0);
        chk("both_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
